// File: rtl/sprite_draw_scheduler_if.sv
// rtl/sprite_draw_scheduler_if.sv - signal bundle between frame timer/sprite FSMs and the draw scheduler
interface sprite_draw_scheduler_if #(
  parameter int N = 4
);
  logic           frame_start;
  logic [N-1:0]   req;
  logic [N-1:0]   done_in;
  logic [N-1:0]   plot_in;
  logic [9*N-1:0] x_in;
  logic [8*N-1:0] y_in;
  logic [3*N-1:0] colour_in;
  logic [N-1:0]   grant;
  logic [8:0]     x_out;
  logic [7:0]     y_out;
  logic [2:0]     colour_out;
  logic           plot_out;
  logic           busy;
  logic           frame_done;
  logic           overrun;
  logic           timeout_err;

  // Requester side: frame timer plus sprite plotters
  modport master (
    output frame_start, req, done_in, plot_in, x_in, y_in, colour_in,
    input  grant, x_out, y_out, colour_out, plot_out, busy, frame_done, overrun, timeout_err
  );

  // Scheduler side
  modport slave (
    input  frame_start, req, done_in, plot_in, x_in, y_in, colour_in,
    output grant, x_out, y_out, colour_out, plot_out, busy, frame_done, overrun, timeout_err
  );
endinterface

// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - grants the VGA write port to sprite plotters in index order; SCHED_TIMEOUT_EN adds a grant watchdog
module sprite_draw_scheduler #(
  parameter int N       = 4,
  parameter int IDXW    = (N > 1) ? $clog2(N) : 1,
  parameter int TIMEOUT = 1023
) (
  input logic                    i_clk,
  input logic                    i_reset,
  sprite_draw_scheduler_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [N-1:0]    r_pending;
  logic [IDXW-1:0] r_idx;

  logic [IDXW-1:0] w_low_idx;
  logic [N-1:0]    w_low_mask;
  logic            w_done_sel;
  logic            w_plot_sel;
  logic [8:0]      w_x_sel;
  logic [7:0]      w_y_sel;
  logic [2:0]      w_colour_sel;
  logic            w_drawing;
  logic            w_timeout;
  logic [N-1:0]    w_grant;

  assign w_drawing = (r_state == S_DRAW);

  // Lowest set bit of the pending mask, scanned high-to-low so the lowest index wins
  always_comb begin
    w_low_idx  = '0;
    w_low_mask = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_low_idx     = IDXW'(i);
        w_low_mask    = '0;
        w_low_mask[i] = 1'b1;
      end
    end
  end

  // Pick the selected sprite's done/plot/coordinates; other sprites' bits are ignored
  always_comb begin
    w_done_sel   = 1'b0;
    w_plot_sel   = 1'b0;
    w_x_sel      = '0;
    w_y_sel      = '0;
    w_colour_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_done_sel   = bus.done_in[i];
        w_plot_sel   = bus.plot_in[i];
        w_x_sel      = bus.x_in[9*i +: 9];
        w_y_sel      = bus.y_in[8*i +: 8];
        w_colour_sel = bus.colour_in[3*i +: 3];
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int WDW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

  logic [WDW-1:0] r_wdog;
  logic           r_timeout_err;

  // Counter equals the number of DRAW cycles already spent; this cycle makes it TIMEOUT
  assign w_timeout = w_drawing && (r_wdog == WDW'(TIMEOUT - 1));

  // Watchdog: restart on every grant, sticky error until reset or an accepted frame_start
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.frame_start)
        r_timeout_err <= 1'b0;
      if (r_state == S_SCAN)
        r_wdog <= '0;
      else if (w_drawing) begin
        r_wdog <= r_wdog + 1'b1;
        if (!w_done_sel && w_timeout)
          r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Pass sequencer: latch requests, then serve each pending sprite once in ascending order
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            r_pending <= bus.req;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_pending == '0) begin
            r_state <= S_DONE;
          end else begin
            r_idx     <= w_low_idx;
            r_pending <= r_pending & ~w_low_mask;
            r_state   <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (w_done_sel || w_timeout)
            r_state <= S_SCAN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-hot grant decoded purely from registered state and index, so it cannot glitch
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < N; i++)
      w_grant[i] = w_drawing && (r_idx == IDXW'(i));
  end

  assign bus.grant      = w_grant;
  assign bus.x_out      = w_drawing ? w_x_sel      : '0;
  assign bus.y_out      = w_drawing ? w_y_sel      : '0;
  assign bus.colour_out = w_drawing ? w_colour_sel : '0;
  assign bus.plot_out   = w_drawing && w_plot_sel;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = (r_state == S_DONE);
  assign bus.overrun    = bus.frame_start && (r_state != S_IDLE);

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb/tb_sprite_draw_scheduler.sv - directed self-checking bench for sprite_draw_scheduler
module tb_sprite_draw_scheduler;

`ifdef SCHED_TIMEOUT_EN
  localparam int TO  = 8;
  localparam int DLY = 5;
`else
  localparam int TO  = 1023;
  localparam int DLY = 560;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  sprite_draw_scheduler_if #(.N(4)) bus();

  sprite_draw_scheduler #(.N(4), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int t_fd;
  int fd_count;
  int bad_grant;

  logic [3:0]  model_mask;
  logic [3:0]  manual_done;
  logic [3:0]  model_done;
  logic [10:0] cnt [4];

  // Sprite plotter model: done pulses DLY cycles after its grant rises
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      cnt[i] <= bus.grant[i] ? cnt[i] + 11'd1 : 11'd0;
  end

  always_comb begin
    model_done = '0;
    for (int i = 0; i < 4; i++)
      model_done[i] = bus.grant[i] && model_mask[i] && (cnt[i] == 11'(DLY));
  end

  assign bus.done_in = model_done | manual_done;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.req         = 4'b0000;
    bus.plot_in     = 4'b1111;
    bus.x_in        = {9'd511, 9'd300, 9'd123, 9'd17};
    bus.y_in        = {8'd255, 8'd200, 8'd66, 8'd5};
    bus.colour_in   = {3'd7, 3'd5, 3'd2, 3'd1};
    model_mask      = 4'b0000;
    manual_done     = 4'b0000;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_plot", 32'(bus.plot_out), 32'd0);
    check("rst_xyc", 32'({bus.x_out, bus.y_out, bus.colour_out}), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);

    // Empty pass: frame_done at cycle 2, busy cycles 1-2
    tick();
    bus.frame_start = 1'b1;
    bus.req         = 4'b0000;
    #1;
    check("empty_c0_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.frame_start = 1'b0;
    #1;
    check("empty_c1_busy", 32'(bus.busy), 32'd1);
    check("empty_c1_fd", 32'(bus.frame_done), 32'd0);
    check("empty_c1_grant", 32'(bus.grant), 32'd0);
    tick();
    #1;
    check("empty_c2_fd", 32'(bus.frame_done), 32'd1);
    check("empty_c2_busy", 32'(bus.busy), 32'd1);
    check("empty_c2_grant", 32'(bus.grant), 32'd0);
    tick();
    #1;
    check("empty_c3_fd", 32'(bus.frame_done), 32'd0);
    check("empty_c3_busy", 32'(bus.busy), 32'd0);

    // Pass serving sprites 1 and 3, with overrun and a foreign done mid-grant
    tick();
    model_mask      = 4'b1111;
    bus.req         = 4'b1010;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    t_fd      = -1;
    fd_count  = 0;
    bad_grant = 0;
    for (int k = 1; k <= 2 * DLY + 12; k++) begin
      if (k == 3) begin
        bus.req         = 4'b1111;
        bus.frame_start = 1'b1;
        manual_done     = 4'b0001;
      end else begin
        bus.frame_start = 1'b0;
      end
      if (k == 5)
        manual_done = 4'b0000;
      #1;
      if (k == 2) begin
        check("p2_first_grant", 32'(bus.grant), 32'b0010);
        check("p2_x1", 32'(bus.x_out), 32'd123);
        check("p2_y1", 32'(bus.y_out), 32'd66);
        check("p2_c1", 32'(bus.colour_out), 32'd2);
        check("p2_plot1", 32'(bus.plot_out), 32'd1);
      end
      if (k == 3)
        check("p3_overrun", 32'(bus.overrun), 32'd1);
      if (k == 4) begin
        check("p3_overrun_end", 32'(bus.overrun), 32'd0);
        check("p4_foreign_done", 32'(bus.grant), 32'b0010);
      end
      if (k == DLY + 2)
        check("p2_last_grant1", 32'(bus.grant), 32'b0010);
      if (k == DLY + 3) begin
        check("p2_gap_grant", 32'(bus.grant), 32'd0);
        check("p2_gap_plot", 32'(bus.plot_out), 32'd0);
        check("p2_gap_x", 32'(bus.x_out), 32'd0);
        check("p2_gap_busy", 32'(bus.busy), 32'd1);
      end
      if (k == DLY + 4) begin
        check("p2_second_grant", 32'(bus.grant), 32'b1000);
        check("p2_x3", 32'(bus.x_out), 32'd511);
        check("p2_y3", 32'(bus.y_out), 32'd255);
        check("p2_c3", 32'(bus.colour_out), 32'd7);
      end
      if (bus.grant[0] || bus.grant[2])
        bad_grant++;
      if (bus.frame_done) begin
        fd_count++;
        t_fd = k;
      end
      tick();
    end
    check("p2_fd_cycle", 32'(t_fd), 32'(2 * DLY + 6));
    check("p2_fd_count", 32'(fd_count), 32'd1);
    check("p3_unrequested", 32'(bad_grant), 32'd0);
    check("p2_idle_after", 32'(bus.busy), 32'd0);
    check("p2_no_timeout", 32'(bus.timeout_err), 32'd0);

    // Reset during DRAW
    bus.req         = 4'b0100;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
    #1;
    check("p5_grant2", 32'(bus.grant), 32'b0100);
    check("p5_x2", 32'(bus.x_out), 32'd300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("p5_grant", 32'(bus.grant), 32'd0);
    check("p5_busy", 32'(bus.busy), 32'd0);
    check("p5_outs", 32'({bus.x_out, bus.y_out, bus.colour_out, bus.plot_out}), 32'd0);
    fd_count = 0;
    for (int k = 0; k < 2 * DLY + 10; k++) begin
      tick();
      #1;
      if (bus.frame_done || bus.grant != 4'b0000)
        fd_count++;
    end
    check("p5_no_frame_done", 32'(fd_count), 32'd0);

`ifdef SCHED_TIMEOUT_EN
    // Watchdog: sprite 0 never finishes
    model_mask      = 4'b0010;
    bus.req         = 4'b0011;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    t_fd = -1;
    for (int k = 1; k <= DLY + 20; k++) begin
      #1;
      if (k == 2)
        check("t6_grant0", 32'(bus.grant), 32'b0001);
      if (k == 9) begin
        check("t6_grant0_last", 32'(bus.grant), 32'b0001);
        check("t6_err_before", 32'(bus.timeout_err), 32'd0);
      end
      if (k == 10) begin
        check("t6_grant_drop", 32'(bus.grant), 32'd0);
        check("t6_err_set", 32'(bus.timeout_err), 32'd1);
      end
      if (k == 11)
        check("t6_grant1", 32'(bus.grant), 32'b0010);
      if (bus.frame_done)
        t_fd = k;
      tick();
    end
    check("t6_fd_cycle", 32'(t_fd), 32'(DLY + 13));
    check("t6_err_sticky", 32'(bus.timeout_err), 32'd1);
    bus.req         = 4'b0000;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    #1;
    check("t6_err_cleared", 32'(bus.timeout_err), 32'd0);
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
Shares the single VGA adapter write port between N sprite plotter FSMs (player, enemy rows, bullets). Each sprite FSM holds `enable` for its whole plot and pulses `done` when finished. On each frame tick, this block latches which sprites want drawing, then grants them one at a time in ascending index order. While a sprite is granted, its x/y/colour/plot are muxed to the VGA adapter. Sits between the game-logic frame timer and the VGA adapter.

Parameters:
- N, 4, number of requesters (1..16).
- IDXW, $clog2(N) (minimum 1), width of the internal selected-index register.
- TIMEOUT, 1023, maximum cycles a grant may be held; used only with SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that starts a draw pass.
- req  in  N  per-sprite draw request; sampled only on an accepted frame_start.
- done_in  in  N  per-sprite done from the sprite FSMs.
- plot_in  in  N  per-sprite pixel-valid.
- x_in  in  9*N  sprite i x is bits [9i+8:9i].
- y_in  in  8*N  sprite i y is bits [8i+7:8i].
- colour_in  in  3*N  sprite i colour is bits [3i+2:3i].
- grant  out  N  one-hot enable to the sprite FSMs.
- x_out  out  9  to VGA adapter.
- y_out  out  8  to VGA adapter.
- colour_out  out  3  to VGA adapter.
- plot_out  out  1  VGA write enable.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when the pass completes.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.
- timeout_err  out  1  sticky error flag (optional feature).

Behaviour:
- Reset values: state = IDLE; pending = 0; idx = 0; grant = 0; plot_out = 0; x_out/y_out/colour_out = 0; busy = 0; frame_done = 0; overrun = 0; timeout_err = 0.
- Reset asserted mid-pass: grant drops at the next edge, pending is cleared, and no frame_done is issued.
- IDLE: on frame_start, pending <= req; go to SCAN.
- SCAN:
  - If pending == 0, go to DONE.
  - Otherwise idx <= lowest set bit of pending, clear that bit, go to DRAW.
- DRAW:
  - grant = one-hot(idx), driven registered or decoded from state so that it is glitch-free.
  - done_in[idx] is sampled every DRAW cycle, including the first. When it is 1, go to SCAN; grant is 0 in the following cycle.
- DONE: frame_done = 1 for exactly one cycle; go to IDLE.
- Latency from frame_start at cycle 0:
  - SCAN at cycle 1; first grant at cycle 2.
  - Between consecutive sprites there is a 1-cycle SCAN gap with grant = 0.
  - If req == 0: frame_done at cycle 2.
- Output mux is combinational from idx:
  - In DRAW: x_out/y_out/colour_out = slice idx of x_in/y_in/colour_in, and plot_out = plot_in[idx].
  - Outside DRAW: all four outputs are 0.
- Ignored inputs:
  - done_in and plot_in bits other than idx.
  - req changes after the latch; they take effect at the next frame_start.
- frame_start while busy: the pass continues unchanged and overrun pulses for 1 cycle.
- Any number of grants per pass is allowed, at most one grant active at a time, and each latched request is served exactly once.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined:
  - A 10-bit-or-wider watchdog counter clears on entry to DRAW and increments each DRAW cycle.
  - If it reaches TIMEOUT without done_in[idx], grant drops, timeout_err is set, and the state goes to SCAN; remaining sprites are still served.
  - timeout_err is cleared by reset or by an accepted frame_start.
- Undefined: no counter exists, timeout_err is tied 0, and DRAW waits indefinitely.

Test Plan:
1. reset then frame_start with req = 4'b0000 -> frame_done pulses at cycle 2; grant stays 0; busy is high for cycles 1-2.
2. req = 4'b1010, with a model FSM that pulses done 560 cycles after its grant rises -> grant = 0010 first, then a 1-cycle gap, then grant = 1000; frame_done follows; x_out/y_out track sprite 1 then sprite 3; plot_out is 0 in the gap.
3. During the pass, change req to 4'b1111 and pulse frame_start -> overrun pulses for 1 cycle; only sprites 1 and 3 are served.
4. Assert done_in[0] while sprite 1 is granted -> ignored; grant[1] holds until done_in[1].
5. Assert reset mid-DRAW -> next cycle grant = 0, busy = 0, all outputs 0; no frame_done.
6. With SCHED_TIMEOUT_EN and TIMEOUT = 8, sprite 0 never done, req = 4'b0011 -> grant[0] drops after 8 cycles; timeout_err = 1; sprite 1 is then served; frame_done pulses.
